oled_spi_ctrl: RTL and testbench

//   Parametrised SPI driver for SSD1306-class monochrome OLED panels.

---
 rtl/oled_spi_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_oled_spi_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_ctrl.sv
// rtl/oled_spi_ctrl.sv - SSD1306-class OLED SPI driver with internal framebuffer
// Power/reset sequencing, init command list and full-frame streaming at CLK_DIV-divided SCLK.
module oled_spi_ctrl #(
  parameter int unsigned STARTUP_WAIT = 32'd10000000,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned COLS         = 128,
  parameter int unsigned PAGES        = 8,
  parameter int unsigned INIT_LEN     = 6,
  parameter logic [8*INIT_LEN-1:0] INIT_CMDS = {8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hAF},
  localparam int unsigned FB_BYTES = COLS * PAGES,
  localparam int unsigned AW = $clog2(FB_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fb_we,
  input  logic [AW-1:0] fb_addr,
  input  logic [7:0]    fb_wdata,
  input  logic          refresh_req,
  input  logic          continuous,
  output logic          busy,
  output logic          frame_done,
  output logic          io_sclk,
  output logic          io_sdin,
  output logic          io_cs,
  output logic          io_dc,
  output logic          io_reset
);

  localparam int unsigned WW   = $clog2(STARTUP_WAIT + 1);
  localparam int unsigned DW   = $clog2(CLK_DIV + 1);
  localparam int unsigned BMAX = (FB_BYTES > INIT_LEN) ? ((FB_BYTES > 6) ? FB_BYTES : 6)
                                                       : ((INIT_LEN > 6) ? INIT_LEN : 6);
  localparam int unsigned BW   = $clog2(BMAX + 1);

  typedef enum logic [2:0] {PWR_WAIT, PWR_RST, PWR_REL, INIT, IDLE, WIN, DATA} state_t;

  state_t          state, state_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic [DW-1:0]   div_cnt, div_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [BW-1:0]   byte_idx, byte_n;
  logic [7:0]      shreg, shreg_n;
  logic            loading, loading_n;
  logic            half, half_n;
  logic            pending, pending_n;
  logic            done_n;
  logic            byte_done;
  logic            send;
  logic [7:0]      byte_val;
  logic [8*INIT_LEN-1:0] init_sh;
  logic [7:0]      fb [FB_BYTES];

  // Framebuffer has no reset so its contents survive a panel restart.
  always_ff @(posedge clk) begin
    if (fb_we && ({1'b0, fb_addr} < (AW+1)'(FB_BYTES)))
      fb[fb_addr] <= fb_wdata;
  end

  assign send    = (state == INIT) || (state == WIN) || (state == DATA);
  assign init_sh = INIT_CMDS << {byte_idx, 3'b000};

  always_comb begin
    byte_val = 8'h00;
    case (state)
      INIT: byte_val = init_sh[8*INIT_LEN-1 -: 8];
      WIN: begin
        case (byte_idx)
          BW'(0):  byte_val = 8'h21;
          BW'(1):  byte_val = 8'h00;
          BW'(2):  byte_val = 8'(COLS - 1);
          BW'(3):  byte_val = 8'h22;
          BW'(4):  byte_val = 8'h00;
          default: byte_val = 8'(PAGES - 1);
        endcase
      end
      DATA:    byte_val = fb[byte_idx[AW-1:0]];
      default: byte_val = 8'h00;
    endcase
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    div_n     = div_cnt;
    bit_n     = bit_cnt;
    byte_n    = byte_idx;
    shreg_n   = shreg;
    loading_n = loading;
    half_n    = half;
    pending_n = pending | (refresh_req && (state != IDLE));
    done_n    = 1'b0;
    byte_done = 1'b0;

    // Bit engine: one load cycle, then 8 x (CLK_DIV low + CLK_DIV high).
    if (send) begin
      if (loading) begin
        shreg_n   = byte_val;
        loading_n = 1'b0;
        bit_n     = 3'd0;
        half_n    = 1'b0;
        div_n     = '0;
      end else if (div_cnt == DW'(CLK_DIV - 1)) begin
        div_n = '0;
        if (!half) begin
          half_n = 1'b1;
        end else begin
          half_n  = 1'b0;
          shreg_n = {shreg[6:0], 1'b0};
          if (bit_cnt == 3'd7) begin
            byte_done = 1'b1;
            loading_n = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end else begin
        div_n = div_cnt + 1'b1;
      end
    end

    case (state)
      PWR_WAIT, PWR_RST, PWR_REL: begin
        if (wait_cnt == WW'(STARTUP_WAIT - 1)) begin
          wait_n = '0;
          case (state)
            PWR_WAIT: state_n = PWR_RST;
            PWR_RST:  state_n = PWR_REL;
            default: begin
              state_n   = INIT;
              loading_n = 1'b1;
              byte_n    = '0;
            end
          endcase
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      INIT: begin
        if (byte_done) begin
          if (byte_idx == BW'(INIT_LEN - 1)) state_n = IDLE;
          else                               byte_n  = byte_idx + 1'b1;
        end
      end
      IDLE: begin
        if (refresh_req || pending || continuous) begin
          state_n   = WIN;
          pending_n = 1'b0;
          loading_n = 1'b1;
          byte_n    = '0;
        end
      end
      WIN: begin
        if (byte_done) begin
          if (byte_idx == BW'(5)) begin
            state_n = DATA;
            byte_n  = '0;
          end else begin
            byte_n = byte_idx + 1'b1;
          end
        end
      end
      DATA: begin
        if (byte_done) begin
          if (byte_idx == BW'(FB_BYTES - 1)) begin
            done_n = 1'b1;
            byte_n = '0;
            if (continuous || pending) begin
              state_n   = WIN;
              pending_n = refresh_req;
            end else begin
              state_n = IDLE;
            end
          end else begin
            byte_n = byte_idx + 1'b1;
          end
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PWR_WAIT;
      wait_cnt   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= 3'd0;
      byte_idx   <= '0;
      shreg      <= 8'h00;
      loading    <= 1'b1;
      half       <= 1'b0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      byte_idx   <= byte_n;
      shreg      <= shreg_n;
      loading    <= loading_n;
      half       <= half_n;
      pending    <= pending_n;
      frame_done <= done_n;
    end
  end

  assign busy     = (state != IDLE);
  assign io_reset = (state != PWR_RST);
  assign io_cs    = !send;
  assign io_dc    = (state == DATA);
  assign io_sclk  = !(send && !loading && !half);
  assign io_sdin  = send && !loading && shreg[7];

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// tb/tb_oled_spi_ctrl.sv - self-checking bench for oled_spi_ctrl
// Small panel geometry keeps multi-frame sequences short; an SPI monitor decodes bytes on SCLK rise.
module tb_oled_spi_ctrl;

  localparam int SW        = 4;
  localparam int CD        = 2;
  localparam int NC        = 6;
  localparam int NP        = 2;
  localparam int FBN       = NC * NP;
  localparam int AWT       = $clog2(FBN);
  localparam int BYTE_CYC  = 1 + 16 * CD;
  localparam int FRAME_CYC = (6 + FBN) * BYTE_CYC;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fb_we = 1'b0;
  logic [AWT-1:0] fb_addr = '0;
  logic [7:0]     fb_wdata = 8'h00;
  logic           refresh_req = 1'b0;
  logic           continuous = 1'b0;
  logic           busy, frame_done, io_sclk, io_sdin, io_cs, io_dc, io_reset;

  oled_spi_ctrl #(
    .STARTUP_WAIT(SW), .CLK_DIV(CD), .COLS(NC), .PAGES(NP), .INIT_LEN(6),
    .INIT_CMDS({8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hAF})
  ) dut (
    .clk(clk), .rst_n(rst_n), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .refresh_req(refresh_req), .continuous(continuous), .busy(busy), .frame_done(frame_done),
    .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc), .io_reset(io_reset)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {logic [7:0] d; logic dc; logic cs;} rec_t;
  typedef struct {string name; logic [7:0] d; logic dc;} bvec_t;
  typedef struct {logic rst; logic cs; logic bsy;} svec_t;
  typedef struct {logic [AWT-1:0] a; logic [7:0] d;} wvec_t;

  rec_t       mq[$];
  bvec_t      hdr[12];
  svec_t      sv[13];
  wvec_t      wv[14];
  logic [7:0] fb_model [FBN];

  int   mbits = 0;
  logic [7:0] msh = 8'h00;

  always @(posedge io_sclk or negedge rst_n) begin
    if (!rst_n) begin
      mbits = 0;
    end else begin
      msh   = {msh[6:0], io_sdin};
      mbits = mbits + 1;
      if (mbits == 8) begin
        mq.push_back('{d: msh, dc: io_dc, cs: io_cs});
        mbits = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string nm, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_bytes(input int base, input int first, input int cnt, input string tag);
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s_%s_d", tag, hdr[first+i].name), 32'(mq[base+i].d), 32'(hdr[first+i].d));
      chk($sformatf("%s_%s_dc", tag, hdr[first+i].name), 32'(mq[base+i].dc), 32'(hdr[first+i].dc));
      chk($sformatf("%s_%s_cs", tag, hdr[first+i].name), 32'(mq[base+i].cs), 32'd0);
    end
  endtask

  task automatic check_frame(input int base, input string tag);
    chk({tag, "_len"}, 32'(mq.size() >= base + 6 + FBN), 32'd1);
    if (mq.size() >= base + 6 + FBN) begin
      chk_bytes(base, 6, 6, tag);
      for (int i = 0; i < FBN; i++) begin
        chk($sformatf("%s_fb%0d_d", tag, i), 32'(mq[base+6+i].d), 32'(fb_model[i]));
        chk($sformatf("%s_fb%0d_dc", tag, i), 32'(mq[base+6+i].dc), 32'd1);
        chk($sformatf("%s_fb%0d_cs", tag, i), 32'(mq[base+6+i].cs), 32'd0);
      end
    end
  endtask

  initial begin
    int n, ndone, d1, d2;

    hdr[0]  = '{"init0", 8'hAE, 1'b0};
    hdr[1]  = '{"init1", 8'h20, 1'b0};
    hdr[2]  = '{"init2", 8'h00, 1'b0};
    hdr[3]  = '{"init3", 8'h8D, 1'b0};
    hdr[4]  = '{"init4", 8'h14, 1'b0};
    hdr[5]  = '{"init5", 8'hAF, 1'b0};
    hdr[6]  = '{"win0", 8'h21, 1'b0};
    hdr[7]  = '{"win1", 8'h00, 1'b0};
    hdr[8]  = '{"win2", 8'h05, 1'b0};
    hdr[9]  = '{"win3", 8'h22, 1'b0};
    hdr[10] = '{"win4", 8'h00, 1'b0};
    hdr[11] = '{"win5", 8'h01, 1'b0};
    for (int k = 0; k < 13; k++)
      sv[k] = '{rst: !(k >= 4 && k <= 7), cs: (k < 12), bsy: 1'b1};
    wv[0] = '{4'd0, 8'hA5};
    for (int i = 1; i <= 10; i++) wv[i] = '{4'(i), 8'(8'h10 + i)};
    wv[11] = '{4'd11, 8'h3C};
    wv[12] = '{4'd12, 8'hFF};
    wv[13] = '{4'd15, 8'hEE};

    // Reset values
    repeat (3) tick();
    chk("rst_sclk", 32'(io_sclk), 32'd1);
    chk("rst_sdin", 32'(io_sdin), 32'd0);
    chk("rst_cs", 32'(io_cs), 32'd1);
    chk("rst_dc", 32'(io_dc), 32'd0);
    chk("rst_reset", 32'(io_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(frame_done), 32'd0);

    // Power sequence: 4 high, 4 low, 4 high, then INIT drops cs
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
      chk($sformatf("pwr%0d_reset", k), 32'(io_reset), 32'(sv[k].rst));
      chk($sformatf("pwr%0d_cs", k), 32'(io_cs), 32'(sv[k].cs));
      chk($sformatf("pwr%0d_busy", k), 32'(busy), 32'(sv[k].bsy));
    end
    wait_idle(1000, "init", n);
    chk("init_count", 32'(mq.size()), 32'd6);
    if (mq.size() >= 6) chk_bytes(0, 0, 6, "init");
    chk("idle_cs", 32'(io_cs), 32'd1);

    // Framebuffer load, including out-of-range addresses that must be dropped
    for (int i = 0; i < 14; i++) begin
      fb_we = 1'b1; fb_addr = wv[i].a; fb_wdata = wv[i].d;
      tick();
      if (int'(wv[i].a) < FBN) fb_model[wv[i].a] = wv[i].d;
    end
    fb_we = 1'b0;

    // Single frame: latency, length, done pulse width
    mq.delete();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    chk("lat_p0_sclk", 32'(io_sclk), 32'd1);
    chk("lat_p0_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_p1_sclk", 32'(io_sclk), 32'd0);
    n = 1;
    while (!frame_done && n < FRAME_CYC + 50) begin
      tick();
      n++;
    end
    chk("frame_cycles", 32'(n), 32'(FRAME_CYC));
    tick();
    chk("done_width", 32'(frame_done), 32'd0);
    chk("frame_idle", 32'(busy), 32'd0);
    chk("frame_count", 32'(mq.size()), 32'(6 + FBN));
    check_frame(0, "f1");

    // Coalesced requests plus a write in data byte 5's load cycle
    mq.delete();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    ndone = 0; d2 = 0;
    for (int c = 1; c <= 2 * FRAME_CYC + 60; c++) begin
      tick();
      if (frame_done) begin ndone++; d2 = c; end
      refresh_req = (c == 100 || c == 200 || c == 300);
      fb_we       = (c == 6 * BYTE_CYC + 5 * BYTE_CYC);
      fb_addr     = 4'd5;
      fb_wdata    = 8'hEE;
    end
    refresh_req = 1'b0; fb_we = 1'b0;
    chk("coal_frames", 32'(ndone), 32'd2);
    chk("coal_last_done", 32'(d2), 32'(2 * FRAME_CYC));
    chk("coal_idle", 32'(busy), 32'd0);
    chk("coal_count", 32'(mq.size()), 32'(2 * (6 + FBN)));
    check_frame(0, "c1");
    fb_model[5] = 8'hEE;
    check_frame(6 + FBN, "c2");

    // Continuous mode, dropped during the second frame
    mq.delete();
    continuous = 1'b1;
    tick();
    ndone = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 3 * FRAME_CYC + 100; c++) begin
      tick();
      if (frame_done) begin
        ndone++;
        if (ndone == 1) d1 = c; else d2 = c;
      end
      if (ndone == 1 && c == d1 + 100) continuous = 1'b0;
    end
    chk("cont_frames", 32'(ndone), 32'd2);
    chk("cont_first", 32'(d1), 32'(FRAME_CYC));
    chk("cont_gap", 32'(d2 - d1), 32'(FRAME_CYC));
    chk("cont_idle", 32'(busy), 32'd0);
    check_frame(0, "k1");
    check_frame(6 + FBN, "k2");

    // Reset during bit 3 of data byte 0
    mq.delete();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    repeat (6 * BYTE_CYC + 1 + 3 * 2 * CD + 1) tick();
    chk("abort_pre_sclk", 32'(io_sclk), 32'd0);
    chk("abort_pre_cs", 32'(io_cs), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(io_cs), 32'd1);
    chk("abort_sclk", 32'(io_sclk), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    mq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle(1000, "restart", n);
    chk("restart_cycles", 32'(n), 32'(3 * SW + 6 * BYTE_CYC));
    chk("restart_count", 32'(mq.size()), 32'd6);
    if (mq.size() >= 6) chk_bytes(0, 0, 6, "reinit");
    mq.delete();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    n = 0;
    while (!frame_done && n < FRAME_CYC + 50) begin
      tick();
      n++;
    end
    chk("kept_cycles", 32'(n), 32'(FRAME_CYC));
    check_frame(0, "kept");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
